imem_responder: RTL and testbench
=================================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256, meaning instruction memory depth in 32-bit words (power of two).
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning response buffer entries.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  fetch request valid.
REQ-006 SHALL have port req_ready  output  1  request can be accepted this cycle.
REQ-007 SHALL have port req_addr  input  ARCH_LEN  byte address of instruction.
REQ-008 SHALL have port rsp_valid  output  1  response at FIFO head valid.
REQ-009 SHALL have port rsp_ready  input  1  fetch stage consumes response.
REQ-010 SHALL have port rsp_inst  output  INST_LEN  instruction word.
REQ-011 SHALL have port rsp_err  output  1  misaligned or out-of-range request.
REQ-012 SHALL have port flush  input  1  redirect; discard all pending responses.
REQ-013 SHALL have port load_we  input  1  program-load word write enable.
REQ-014 SHALL have port load_addr  input  ARCH_LEN  byte address of load word (word-aligned).
REQ-015 SHALL have port load_data  input  INST_LEN  load word.
REQ-016 SHALL have port err_cnt  output  8  saturating count of error responses issued.

Function
REQ-017 Request SHALL be accepted on a rising edge where req_valid && req_ready.
REQ-018 req_ready SHALL = (fifo_count < FIFO_DEPTH) && !flush && !load_we; no combinational path from rsp_ready.
REQ-019 Accepted request SHALL be read synchronously at the accept edge and pushed to the FIFO; rsp_valid SHALL be high the following cycle (latency 1).
REQ-020 Word index SHALL be req_addr[log2(MEM_WORDS)+1:2].
REQ-021 req_addr[1:0] != 0 SHALL give rsp_err=1, rsp_inst=NOP_INST (0x00000013).
REQ-022 req_addr >= MEM_WORDS*4 SHALL give rsp_err=1, rsp_inst=NOP_INST; misalignment checked first, same result.
REQ-023 Response SHALL be popped on a rising edge where rsp_valid && rsp_ready; responses SHALL leave in acceptance order.
REQ-024 Simultaneous push and pop with FIFO full or empty SHALL keep fifo_count unchanged and lose no data.
REQ-025 rsp_inst/rsp_err SHALL hold stable while rsp_valid && !rsp_ready.
REQ-026 flush SHALL empty the FIFO at that edge; rsp_valid SHALL be 0 the next cycle; no request is accepted in a flush cycle.
REQ-027 load_we SHALL write load_data to word load_addr[...:2] at the edge; out-of-range load writes SHALL be ignored.
REQ-028 A request accepted the cycle after a load to the same word SHALL return the new data.
REQ-029 err_cnt SHALL increment on each error-response push, saturating at 255; flushed errors stay counted.
REQ-030 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-031 While rst=0: fifo_count=0, rsp_valid=0, req_ready=0, err_cnt=0, pointers=0.
REQ-032 req_ready SHALL go high the first cycle after rst deasserts; memory contents SHALL NOT be reset.
REQ-033 Reset mid-operation SHALL discard all pending responses immediately (asynchronous).

Structure
REQ-034 MEM_WORDS default and NOP_INST SHALL live in constants_pkg; ARCH_LEN/INST_LEN reused from there.
REQ-035 typedef imem_rsp_t {inst, err} SHALL live in instruction_pkg.
REQ-036 FIFO SHALL be sub-module imem_rsp_fifo (parameterised depth, payload imem_rsp_t, count output).

Verification
REQ-037 Load 0xDEADBEEF at 0x10, request 0x10 with rsp_ready=1 -> rsp_valid next cycle, rsp_inst=0xDEADBEEF, rsp_err=0.
REQ-038 rsp_ready=0, issue requests 0x0,0x4,0x8 back-to-back -> two accepted, req_ready=0 on third; raise rsp_ready -> responses in order, third accepted after first pop.
REQ-039 Request 0x2 then 0x400 (MEM_WORDS=256) -> both rsp_err=1, rsp_inst=0x00000013, err_cnt=2.
REQ-040 FIFO full, assert flush one cycle -> rsp_valid=0 next cycle, no request accepted in flush cycle, err_cnt unchanged.
REQ-041 Streaming 8 requests with rsp_ready=1 -> one response per cycle, no bubbles, pointers wrap cleanly.
REQ-042 Assert rst low with 2 pending responses -> rsp_valid=0 immediately, err_cnt=0; after release req_ready=1, prior memory data still read back.

Source files
------------

// File: rtl/constants_pkg.sv
`default_nettype none
// constants_pkg -- architecture widths and fetch-path constants shared across the core (rev 1.0)
package constants_pkg;
  localparam int ARCH_LEN          = 32;
  localparam int INST_LEN          = 32;
  localparam int DEFAULT_MEM_WORDS = 256;
  localparam logic [INST_LEN-1:0] NOP_INST = 32'h0000_0013;
endpackage
`default_nettype wire

// File: rtl/instruction_pkg.sv
`default_nettype none
// instruction_pkg -- instruction-fetch payload types (rev 1.0)
package instruction_pkg;
  import constants_pkg::*;

  typedef struct packed {
    logic [INST_LEN-1:0] inst;
    logic                err;
  } imem_rsp_t;
endpackage
`default_nettype wire

// File: rtl/imem_responder_if.sv
`default_nettype none
// imem_responder_if -- fetch request/response, flush and program-load signals (rev 1.0)
interface imem_responder_if;
  import constants_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [ARCH_LEN-1:0] req_addr;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [INST_LEN-1:0] rsp_inst;
  logic                rsp_err;
  logic                flush;
  logic                load_we;
  logic [ARCH_LEN-1:0] load_addr;
  logic [INST_LEN-1:0] load_data;
  logic [7:0]          err_cnt;

  modport master (
    output req_valid, req_addr, rsp_ready, flush, load_we, load_addr, load_data,
    input  req_ready, rsp_valid, rsp_inst, rsp_err, err_cnt
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, flush, load_we, load_addr, load_data,
    output req_ready, rsp_valid, rsp_inst, rsp_err, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/imem_rsp_fifo.sv
`default_nettype none
// imem_rsp_fifo -- circular response buffer with occupancy count and synchronous flush (rev 1.0)
module imem_rsp_fifo
  import instruction_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  imem_rsp_t        push_data,
  input  logic             pop,
  output imem_rsp_t        head,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  imem_rsp_t        slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full FIFO may still take a push when the head leaves on the same edge.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign head    = slots[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      slots[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// imem_responder -- loadable instruction memory answering fetch requests through a response FIFO;
// rev 1.0
module imem_responder
  import constants_pkg::*;
  import instruction_pkg::*;
#(
  parameter int MEM_WORDS  = DEFAULT_MEM_WORDS,
  parameter int FIFO_DEPTH = 2
) (
  input logic             clk,
  input logic             rst,
  imem_responder_if.slave bus
);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ARCH_LEN-1:0] MEM_BYTES = ARCH_LEN'(MEM_WORDS * 4);

  logic [INST_LEN-1:0] mem [MEM_WORDS];
  logic [IDX_W-1:0]    rd_idx;
  logic [IDX_W-1:0]    wr_idx;
  logic                started;
  logic                ready;
  logic                valid;
  logic                accept;
  logic                pop;
  logic                req_err;
  logic                load_ok;
  logic [CNT_W-1:0]    fifo_count;
  logic [7:0]          err_count;
  imem_rsp_t           push_rsp;
  imem_rsp_t           head_rsp;

  assign rd_idx  = bus.req_addr[IDX_W+1:2];
  assign wr_idx  = bus.load_addr[IDX_W+1:2];
  assign req_err = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr >= MEM_BYTES);
  assign load_ok = bus.load_we && (bus.load_addr < MEM_BYTES);

  // started holds ready low until the first edge after reset release.
  assign ready  = started && (fifo_count < CNT_W'(FIFO_DEPTH)) && !bus.flush && !bus.load_we;
  assign valid  = (fifo_count != '0);
  assign accept = bus.req_valid && ready;
  assign pop    = valid && bus.rsp_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started <= 1'b0;
    end else begin
      started <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (load_ok) begin
      mem[wr_idx] <= bus.load_data;
    end
  end

  always_comb begin
    push_rsp.inst = mem[rd_idx];
    push_rsp.err  = 1'b0;
    if (req_err) begin
      push_rsp.inst = NOP_INST;
      push_rsp.err  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_count <= 8'd0;
    end else if (accept && push_rsp.err && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

  imem_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush),
    .push      (accept),
    .push_data (push_rsp),
    .pop       (pop),
    .head      (head_rsp),
    .count     (fifo_count)
  );

  assign bus.req_ready = ready;
  assign bus.rsp_valid = valid;
  assign bus.rsp_inst  = head_rsp.inst;
  assign bus.rsp_err   = head_rsp.err;
  assign bus.err_cnt   = err_count;
endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// tb_imem_responder -- vector table, directed corner sequences and random traffic vs. a queue model
module tb_imem_responder;
  logic clk;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  imem_responder_if bus ();

  imem_responder #(
    .MEM_WORDS  (256),
    .FIFO_DEPTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Reference model: memory image, ordered list of outstanding responses, error tally.
  logic [31:0] mem_m [256];
  logic [32:0] q [$];
  int          cnt_m = 0;
  bit          alive = 1'b0;

  typedef struct {
    bit          rv;
    logic [31:0] ra;
    bit          rr;
    bit          lw;
    logic [31:0] la;
    logic [31:0] ld;
    bit          e_rdy;
    bit          e_vld;
    logic [31:0] e_inst;
    bit          e_err;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] ref_rsp(input logic [31:0] a);
    if ((a % 4) != 0 || a >= 32'd1024) return {1'b1, 32'h0000_0013};
    return {1'b0, mem_m[a / 4]};
  endfunction

  function automatic bit exp_ready();
    return alive && (q.size() < 2) && !bus.flush && !bus.load_we;
  endfunction

  task automatic drive(input bit v, input logic [31:0] a, input bit r, input bit f,
                       input bit w, input logic [31:0] wa, input logic [31:0] wd);
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.rsp_ready = r;
    bus.flush     = f;
    bus.load_we   = w;
    bus.load_addr = wa;
    bus.load_data = wd;
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [32:0] h;
    chk({tag, ".rdy"}, 32'(bus.req_ready), 32'(exp_ready()));
    chk({tag, ".vld"}, 32'(bus.rsp_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      h = q[0];
      chk({tag, ".inst"}, bus.rsp_inst, h[31:0]);
      chk({tag, ".err"}, 32'(bus.rsp_err), 32'(h[32]));
    end
    chk({tag, ".errcnt"}, 32'(bus.err_cnt), 32'(cnt_m));
  endtask

  task automatic advance();
    bit          acc;
    bit          pop;
    logic [32:0] r;
    acc = bus.req_valid && exp_ready();
    pop = bus.rsp_ready && (q.size() != 0);
    r   = ref_rsp(bus.req_addr);
    if (bus.flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back(r);
        if (r[32] && cnt_m < 255) cnt_m++;
      end
    end
    if (bus.load_we && bus.load_addr < 32'd1024) mem_m[bus.load_addr / 4] = bus.load_data;
    if (rst) alive = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int          pops;
    int          sel;
    logic [31:0] a;

    tbl[0]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,         1'b0, 8'd0};
    tbl[1]  = '{1'b1, 32'h10,  1'b1, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 8'd0};
    tbl[2]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,  32'h0,         1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 8'd0};
    tbl[4]  = '{1'b1, 32'h4,   1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b1, 32'hC0DE_0000, 1'b0, 8'd0};
    tbl[5]  = '{1'b1, 32'h8,   1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b1, 32'hC0DE_0000, 1'b0, 8'd0};
    tbl[6]  = '{1'b1, 32'h8,   1'b1, 1'b0, 32'h0,  32'h0,         1'b0, 1'b1, 32'hC0DE_0000, 1'b0, 8'd0};
    tbl[7]  = '{1'b1, 32'h8,   1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b1, 32'hC0DE_0001, 1'b0, 8'd0};
    tbl[8]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,  32'h0,         1'b0, 1'b1, 32'hC0DE_0001, 1'b0, 8'd0};
    tbl[9]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,  32'h0,         1'b1, 1'b1, 32'hC0DE_0002, 1'b0, 8'd0};
    tbl[10] = '{1'b1, 32'h2,   1'b1, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 8'd0};
    tbl[11] = '{1'b1, 32'h400, 1'b1, 1'b0, 32'h0,  32'h0,         1'b1, 1'b1, 32'h0000_0013, 1'b1, 8'd1};
    tbl[12] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,  32'h0,         1'b1, 1'b1, 32'h0000_0013, 1'b1, 8'd2};
    tbl[13] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 8'd2};

    rst = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h0;
    bus.rsp_ready = 1'b0;
    bus.flush     = 1'b0;
    bus.load_we   = 1'b0;
    bus.load_addr = 32'h0;
    bus.load_data = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset.rdy", 32'(bus.req_ready), 32'd0);
    chk("reset.vld", 32'(bus.rsp_valid), 32'd0);
    chk("reset.errcnt", 32'(bus.err_cnt), 32'd0);
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_model("release");
    advance();

    // Program load of a known image
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'(i * 4), 32'hC0DE_0000 + 32'(i));
      check_model("preload");
      advance();
    end

    // Vector table: load/fetch, backpressure ordering, error responses
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rv, tbl[i].ra, tbl[i].rr, 1'b0, tbl[i].lw, tbl[i].la, tbl[i].ld);
      chk($sformatf("tbl%0d.rdy", i), 32'(bus.req_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d.vld", i), 32'(bus.rsp_valid), 32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d.errcnt", i), 32'(bus.err_cnt), 32'(tbl[i].e_cnt));
      if (tbl[i].e_vld) begin
        chk($sformatf("tbl%0d.inst", i), bus.rsp_inst, tbl[i].e_inst);
        chk($sformatf("tbl%0d.err", i), 32'(bus.rsp_err), 32'(tbl[i].e_err));
      end
      advance();
    end

    // Flush with a full buffer holding one error response
    drive(1'b1, 32'h3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_model("fill0");
    advance();
    drive(1'b1, 32'h14, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_model("fill1");
    advance();
    drive(1'b1, 32'h18, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    check_model("flush");
    chk("flush.rdy_low", 32'(bus.req_ready), 32'd0);
    advance();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check_model("post_flush");
    chk("post_flush.vld_low", 32'(bus.rsp_valid), 32'd0);
    chk("post_flush.errcnt", 32'(bus.err_cnt), 32'd3);
    advance();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("flush_no_accept", 32'(bus.rsp_valid), 32'd0);
    advance();

    // Fetch the cycle after a load to the same word
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h40, 32'h1234_5678);
    check_model("ldfwd.load");
    advance();
    drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check_model("ldfwd.req");
    advance();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check_model("ldfwd.rsp");
    chk("ldfwd.inst", bus.rsp_inst, 32'h1234_5678);
    advance();

    // Out-of-range load must not alias onto word 0
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h400, 32'hBAD0_BAD0);
    check_model("oor.load");
    advance();
    drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check_model("oor.req");
    advance();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check_model("oor.rsp");
    chk("oor.inst", bus.rsp_inst, 32'hC0DE_0000);
    advance();

    // Eight back-to-back fetches with the consumer always ready
    pops = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 32'h20 + 32'(k * 4), 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      check_model($sformatf("stream%0d", k));
      if (bus.rsp_valid) pops++;
      advance();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check_model("stream_tail");
    if (bus.rsp_valid) pops++;
    advance();
    chk("stream.pops", 32'(pops), 32'd8);

    // Asynchronous reset with two responses pending
    drive(1'b1, 32'h5, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    advance();
    drive(1'b1, 32'h24, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    advance();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("pre_rst.vld", 32'(bus.rsp_valid), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("async_rst.vld", 32'(bus.rsp_valid), 32'd0);
    chk("async_rst.errcnt", 32'(bus.err_cnt), 32'd0);
    chk("async_rst.rdy", 32'(bus.req_ready), 32'd0);
    q.delete();
    cnt_m = 0;
    alive = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_model("rst_release");
    advance();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_model("rst_first");
    chk("post_rst.rdy", 32'(bus.req_ready), 32'd1);
    advance();
    drive(1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check_model("rst_req");
    advance();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check_model("rst_rsp");
    chk("mem_kept.inst", bus.rsp_inst, 32'hDEAD_BEEF);
    advance();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      sel = int'($urandom % 8);
      if (sel == 0)      a = 32'(($urandom % 64) * 4 + 1 + ($urandom % 3));
      else if (sel == 1) a = $urandom | 32'h0000_0400;
      else               a = 32'(($urandom % 64) * 4);
      drive(($urandom % 4) != 0, a, ($urandom % 4) != 0, ($urandom % 16) == 0,
            ($urandom % 8) == 0,
            (($urandom % 16) == 0) ? 32'h0000_0800 : 32'(($urandom % 64) * 4),
            $urandom);
      check_model("rand");
      advance();
    end

    // Error counter saturation
    for (int n = 0; n < 260; n++) begin
      drive(1'b1, 32'(($urandom % 256) * 4 + 1), 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      check_model("sat");
      advance();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check_model("sat_tail");
    chk("errcnt.saturated", 32'(bus.err_cnt), 32'd255);
    advance();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
